// File: rtl/booth_seq_mul.sv
// Sequential radix-4 Booth multiplier: 24x24 signed -> 48-bit product.
// Retires one Booth digit per RUN cycle, with valid/ready handshakes on both sides.
module booth_seq_mul (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [23:0] i_a,
    input  logic [23:0] i_b,
    input  logic        i_abort,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [47:0] o_product,
    output logic [2:0]  o_digit,
    output logic        o_busy
);

    // state  | meaning
    // S_IDLE | waiting for operands, in_ready high
    // S_RUN  | retiring one Booth digit per cycle, cnt 0..11
    // S_DONE | product held until the consumer takes it
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [47:0] r_mcand;
    logic [47:0] r_acc;
    logic [24:0] r_bsh;
    logic [3:0]  r_cnt;
    logic [2:0]  w_digit;
    logic [47:0] w_pp;
    logic [47:0] w_pp_sh;

    // Sign-magnitude digit: bit2 = sign, bits1:0 = magnitude.
    always_comb begin
        w_digit = 3'b000;
        case (r_bsh[2:0])
            3'b001:  w_digit = 3'b001;
            3'b010:  w_digit = 3'b001;
            3'b011:  w_digit = 3'b010;
            3'b100:  w_digit = 3'b110;
            3'b101:  w_digit = 3'b101;
            3'b110:  w_digit = 3'b101;
            default: w_digit = 3'b000;
        endcase
    end

    always_comb begin
        w_pp = '0;
        case (w_digit[1:0])
            2'b01:   w_pp = r_mcand;
            2'b10:   w_pp = {r_mcand[46:0], 1'b0};
            default: w_pp = '0;
        endcase
        if (w_digit[2]) begin
            w_pp = -w_pp;
        end
    end

    assign w_pp_sh = w_pp << {r_cnt, 1'b0};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort takes priority over the final digit so a cancelled op never presents a result.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_in_valid) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 4'd11) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (i_out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_bsh   <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_IDLE && i_in_valid) begin
            r_mcand <= {{24{i_a[23]}}, i_a};
            r_bsh   <= {i_b, 1'b0};
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_RUN && !i_abort) begin
            r_acc   <= r_acc + w_pp_sh;
            r_bsh   <= {{2{r_bsh[24]}}, r_bsh[24:2]};
            r_cnt   <= r_cnt + 4'd1;
        end
    end

    assign o_in_ready  = (r_state == S_IDLE);
    assign o_out_valid = (r_state == S_DONE);
    assign o_busy      = (r_state == S_RUN);
    assign o_product   = (r_state == S_DONE) ? r_acc : 48'd0;
    assign o_digit     = (r_state == S_RUN) ? w_digit : 3'b000;

endmodule
